// File: rtl/csa_accumulator.sv
// Carry-save multi-operand accumulator. It keeps a redundant sum/carry pair while operands
// stream in, ripples the pair down to a binary result after the last operand, and then
// presents that result on a valid/ready port.
module csa_accumulator #(
  parameter int unsigned W     = 4,
  parameter int unsigned ACC_W = 8,
  parameter int unsigned CNT_W = 8
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic [W-1:0]     in_data_i,
  input  logic             in_last_i,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [ACC_W-1:0] out_sum_o,
  output logic             out_ovf_o,
  output logic [CNT_W-1:0] out_count_o
);

  localparam logic [1:0] StAccum   = 2'd0;
  localparam logic [1:0] StResolve = 2'd1;
  localparam logic [1:0] StOutput  = 2'd2;

  logic [1:0]       state_q, state_d;
  logic [ACC_W-1:0] s_q, s_d;
  logic [ACC_W-1:0] c_q, c_d;
  logic             ovf_q, ovf_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic [ACC_W-1:0] x;
  logic [ACC_W-1:0] maj_acc;
  logic [ACC_W-1:0] gen_res;
  logic             accept;

  assign x       = {{(ACC_W - W){1'b0}}, in_data_i};
  // Per-bit carry of the 3:2 compressor used while accumulating.
  assign maj_acc = (s_q & c_q) | (s_q & x) | (c_q & x);
  // Per-bit carry of the 2:2 half-adder step used while resolving.
  assign gen_res = s_q & c_q;

  assign in_ready_o  = (state_q == StAccum);
  assign out_valid_o = (state_q == StOutput);
  assign accept      = in_valid_i & in_ready_o;

  // Outputs are gated to zero unless a result is being presented.
  always_comb begin
    out_sum_o   = '0;
    out_ovf_o   = 1'b0;
    out_count_o = '0;
    if (out_valid_o) begin
      out_sum_o   = s_q;
      out_ovf_o   = ovf_q;
      out_count_o = cnt_q;
    end
  end

  // Next-state: accumulate, resolve the redundant pair, then hold the result.
  always_comb begin
    state_d = state_q;
    s_d     = s_q;
    c_d     = c_q;
    ovf_d   = ovf_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      StAccum: begin
        if (accept) begin
          s_d   = s_q ^ c_q ^ x;
          c_d   = maj_acc << 1;
          // A carry out of the top bit weighs 2^ACC_W and is lost from the pair.
          ovf_d = ovf_q | maj_acc[ACC_W-1];
          cnt_d = (cnt_q == {CNT_W{1'b1}}) ? cnt_q : cnt_q + 1'b1;
          if (in_last_i) begin
            state_d = StResolve;
          end
        end
      end
      StResolve: begin
        if (c_q == '0) begin
          state_d = StOutput;
        end else begin
          s_d   = s_q ^ c_q;
          c_d   = gen_res << 1;
          ovf_d = ovf_q | gen_res[ACC_W-1];
        end
      end
      StOutput: begin
        if (out_ready_i) begin
          state_d = StAccum;
          s_d     = '0;
          c_d     = '0;
          ovf_d   = 1'b0;
          cnt_d   = '0;
        end
      end
      default: begin
        state_d = StAccum;
        s_d     = '0;
        c_d     = '0;
        ovf_d   = 1'b0;
        cnt_d   = '0;
      end
    endcase
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q <= StAccum;
      s_q     <= '0;
      c_q     <= '0;
      ovf_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      s_q     <= s_d;
      c_q     <= c_d;
      ovf_q   <= ovf_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule

// File: tb/tb_csa_accumulator.sv
// Bench for csa_accumulator: directed frames with literal expectations plus a frame-sum
// model checked against the DUT on every cycle.
module tb_csa_accumulator;

  localparam int W     = 4;
  localparam int ACC_W = 8;
  localparam int CNT_W = 8;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             in_valid;
  logic             in_ready;
  logic [W-1:0]     in_data;
  logic             in_last;
  logic             out_valid;
  logic             out_ready;
  logic [ACC_W-1:0] out_sum;
  logic             out_ovf;
  logic [CNT_W-1:0] out_count;

  int vectors = 0;
  int miscompares = 0;

  typedef struct {
    int sum;
    int n;
  } frame_t;

  frame_t exp_q[$];

  csa_accumulator #(
    .W    (W),
    .ACC_W(ACC_W),
    .CNT_W(CNT_W)
  ) dut (
    .clk_i      (clk),
    .rst_ni     (rst_n),
    .in_valid_i (in_valid),
    .in_ready_o (in_ready),
    .in_data_i  (in_data),
    .in_last_i  (in_last),
    .out_valid_o(out_valid),
    .out_ready_i(out_ready),
    .out_sum_o  (out_sum),
    .out_ovf_o  (out_ovf),
    .out_count_o(out_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Compare process: frame sums taken from accepted beats, checked every cycle.
  initial begin : compare
    int  acc_sum;
    int  acc_n;
    bit  in_resolve;
    int  res_cycles;
    bit  prev_take;
    int  es;
    int  eo;
    int  ec;
    acc_sum = 0; acc_n = 0; in_resolve = 0; res_cycles = 0; prev_take = 0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        acc_sum = 0; acc_n = 0; in_resolve = 0; res_cycles = 0; prev_take = 0;
        exp_q.delete();
        continue;
      end
      if (prev_take) check("in_ready_after_take", 32'(in_ready), 1);
      if (out_valid) begin
        check("in_ready_low_in_output", 32'(in_ready), 0);
        if (exp_q.size() == 0) begin
          check("spurious_out_valid", 32'(out_valid), 0);
        end else begin
          es = exp_q[0].sum % (1 << ACC_W);
          eo = (exp_q[0].sum >= (1 << ACC_W)) ? 1 : 0;
          ec = (exp_q[0].n > 255) ? 255 : exp_q[0].n;
          check("model_sum", 32'(out_sum), 32'(es));
          check("model_ovf", 32'(out_ovf), 32'(eo));
          check("model_count", 32'(out_count), 32'(ec));
        end
        if (in_resolve) begin
          check("resolve_len_max", 32'(res_cycles <= ACC_W + 1), 1);
          check("resolve_len_min", 32'(res_cycles >= 1), 1);
          in_resolve = 0;
        end
      end else begin
        check("idle_outputs_zero", {out_sum, out_ovf, out_count}, 0);
        if (in_resolve) begin
          res_cycles++;
          if (res_cycles > ACC_W + 2) begin
            check("resolve_len_max", 32'(res_cycles), ACC_W + 1);
            in_resolve = 0;
          end
        end
      end
      if (in_valid && in_ready) begin
        acc_sum += int'(in_data);
        acc_n++;
        if (in_last) begin
          exp_q.push_back('{sum: acc_sum, n: acc_n});
          acc_sum = 0; acc_n = 0;
          in_resolve = 1; res_cycles = 0;
        end
      end
      prev_take = out_valid && out_ready;
      if (prev_take && exp_q.size() > 0) void'(exp_q.pop_front());
    end
  end

  // Present one operand; optional idle gap with garbage on the ignored inputs.
  task automatic put(input logic [W-1:0] d, input bit last, input bit gaps);
    int guard;
    guard = 0;
    if (gaps) begin
      repeat ($urandom_range(0, 2)) begin
        in_valid = 1'b0; in_data = W'($urandom); in_last = 1'($urandom);
        @(posedge clk); #1;
      end
    end
    while (!in_ready && guard < 100) begin
      @(posedge clk); #1; guard++;
    end
    if (!in_ready) begin
      check("in_ready_timeout", 32'(in_ready), 1);
    end
    in_valid = 1'b1; in_data = d; in_last = last;
    @(posedge clk); #1;
    in_valid = 1'b0; in_data = W'($urandom); in_last = 1'($urandom);
  endtask

  // Wait for a result, check literals, optionally stall the consumer, then consume.
  task automatic expect_result(input int s, input int o, input int c, input int wait_exp,
                               input int hold);
    int waited;
    waited = 0;
    out_ready = (hold == 0);
    while (!out_valid && waited < 50) begin
      @(posedge clk); #1; waited++;
    end
    if (!out_valid) begin
      check("out_valid_timeout", 32'(out_valid), 1);
    end else begin
      check("lit_sum", 32'(out_sum), 32'(s));
      check("lit_ovf", 32'(out_ovf), 32'(o));
      check("lit_count", 32'(out_count), 32'(c));
      if (wait_exp >= 0) check("lit_latency", 32'(waited), 32'(wait_exp));
      repeat (hold) begin
        in_valid = 1'($urandom); in_data = W'($urandom); in_last = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        check("hold_sum", 32'(out_sum), 32'(s));
        check("hold_in_ready", 32'(in_ready), 0);
      end
      out_ready = 1'b1;
      @(posedge clk); #1;
      check("out_valid_drop", 32'(out_valid), 0);
      check("in_ready_rise", 32'(in_ready), 1);
    end
  endtask

  // Random consumer: out_ready toggles until the result is taken.
  task automatic drain_random();
    int  g;
    bit  done;
    g = 0; done = 0;
    while (!done && g < 200) begin
      out_ready = 1'($urandom_range(0, 1));
      done = out_valid && out_ready;
      @(posedge clk); #1; g++;
    end
    if (!done) check("drain_timeout", 32'(done), 1);
    out_ready = 1'b1;
  endtask

  initial begin : stim
    int n;
    rst_n = 1'b0; in_valid = 1'b0; in_data = '0; in_last = 1'b0; out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("rst_in_ready", 32'(in_ready), 1);
    check("rst_out_valid", 32'(out_valid), 0);
    check("rst_outputs", {out_sum, out_ovf, out_count}, 0);
    rst_n = 1'b1;

    // 1+5+5: one resolve iteration, so two resolve cycles.
    put(4'd1, 0, 0); put(4'd5, 0, 0); put(4'd5, 1, 0);
    expect_result(11, 0, 3, 2, 0);

    put(4'd15, 0, 0); put(4'd15, 0, 0); put(4'd15, 1, 0);
    expect_result(45, 0, 3, -1, 0);
    put(4'd7, 0, 0); put(4'd6, 0, 0); put(4'd8, 1, 0);
    expect_result(21, 0, 3, -1, 0);

    for (int i = 0; i < 18; i++) put(4'd15, i == 17, 0);
    expect_result(14, 1, 18, -1, 0);
    put(4'd12, 1, 0);
    expect_result(12, 0, 1, 1, 0);

    // Consumer stalls for 5 cycles with in_valid pulses that must be ignored.
    put(4'd3, 0, 0); put(4'd4, 1, 0);
    expect_result(7, 0, 2, 1, 5);

    // Reset during resolve.
    put(4'd15, 0, 0); put(4'd5, 0, 0); put(4'd2, 1, 0);
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    check("midrst_in_ready", 32'(in_ready), 1);
    check("midrst_out_valid", 32'(out_valid), 0);
    check("midrst_outputs", {out_sum, out_ovf, out_count}, 0);
    put(4'd12, 0, 0); put(4'd6, 0, 0); put(4'd11, 1, 0);
    expect_result(29, 0, 3, -1, 0);

    // 300 x 15 = 4500 = 17*256 + 148, count saturates.
    for (int i = 0; i < 300; i++) put(4'd15, i == 299, 1);
    expect_result(148, 1, 255, -1, 0);

    // Random frames, checked by the compare process.
    for (int f = 0; f < 300; f++) begin
      n = (f == 150) ? 300 : $urandom_range(1, 24);
      for (int i = 0; i < n; i++) put(W'($urandom), i == n - 1, 1);
      drain_random();
    end

    repeat (3) @(posedge clk);
    #1;
    check("queue_empty", 32'(exp_q.size()), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
